pipe_ctrl_stage: RTL and testbench
==================================

Name: pipe_ctrl_stage

Overview:
- Parametrised pipeline-stage register for control bundles between any two pipeline stages (ID/EX, EX/MEM, MEM/WB).
- Replaces per-stage hand-written flush/valid registers with one block.
- Adds a valid/ready handshake, an optional skid entry for full throughput under back-pressure, and selective flush that preserves entries tagged noflush.

Parameters:
- WIDTH, 16, payload (control bundle) width in bits.
- SKID, 1, 1 = two-entry (main + skid) with registered in_ready; 0 = single entry with combinational in_ready.
- RESET_VAL, 0, value of payload registers after reset (WIDTH bits).
- FLUSH_VAL, 0, value written into payload registers of a flushed entry (WIDTH bits).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage can accept a beat this cycle.
- in_data  input  WIDTH  upstream control bundle.
- in_noflush  input  1  beat is immune to flush.
- flush  input  1  kill all non-noflush entries, including a beat accepted this cycle.
- out_valid  output  1  main entry holds a live beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  WIDTH  main entry payload.
- out_noflush  output  1  main entry noflush tag.
- occupancy  output  2  live entries held (0..2; max 1 when SKID=0).

Behaviour:
- Reset (async, highest priority):
  - main_valid = skid_valid = 0.
  - out_data and skid payload = RESET_VAL; noflush tags = 0.
  - occupancy = 0; in_ready = 1 once reset deasserts.
- Transfer definitions:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - A popped beat counts as delivered even when flush is high in the same cycle.
- in_ready, SKID=1: registered, equals !skid_valid.
- in_ready, SKID=0: combinational, equals !main_valid | out_ready.
- Latency: accepted beat appears on out_* the next cycle when main is empty or popping. There is no combinational in->out path.
- Normal operation (flush=0), each edge, ordered oldest first:
  - Candidate list = {main if valid and not popped, skid if valid, incoming if accept}.
  - First candidate goes to main, second to skid.
  - Skid drains into main on a pop. Order is strictly FIFO.
  - Ordering invariant: skid_valid implies main_valid.
- Flush (flush=1, reset=0):
  - Build the same candidate list, then drop every candidate whose noflush tag = 0.
  - Compact survivors oldest-first into main, then skid.
  - Registers left empty take payload FLUSH_VAL and noflush tag 0.
- Bubble: while main_valid = 0, out_data = FLUSH_VAL (or RESET_VAL if no beat has loaded since reset). Downstream must qualify with out_valid.
- Back-pressure, SKID=1:
  - Main full, out_ready = 0, accept → beat goes to skid; in_ready falls the next cycle.
  - No beat is ever overwritten or lost.
- Back-pressure, SKID=0: accept while full occurs only when popping in the same cycle.
- Simultaneous accept and pop with main full and skid empty: main takes incoming; occupancy unchanged.
- Reset asserted mid-transfer: all entries discarded immediately (async), including any beat handshaken in that cycle.
- occupancy = main_valid + skid_valid, registered.

Test Plan:
- Reset, then WIDTH=16 beats 0x0001..0x0004 with out_ready=1 continuously → out_data 0x0001..0x0004 on consecutive cycles, one cycle after each accept; in_ready stays 1; occupancy 1.
- Load 0x00A1, hold out_ready=0, send 0x00A2 → skid holds 0x00A2; in_ready=0 next cycle; occupancy=2. Release out_ready → 0x00A1 then 0x00A2 with no gap.
- Fill main=0x0011 (noflush=0), skid=0x0022 (noflush=1), flush=1 with in_valid=0 → main=0x0022, out_noflush=1, occupancy=1, skid payload=FLUSH_VAL.
- flush=1 with accept of 0x0033 (in_noflush=0) into empty stage → out_valid=0, occupancy=0, out_data=FLUSH_VAL.
- flush=1 with pop of main=0x0044 in same cycle → 0x0044 counted as delivered (monitor sees handshake); no duplicate on the next cycle.
- Assert reset asynchronously mid-cycle with occupancy=2 → out_valid, occupancy and out_data drop to 0/0/RESET_VAL before the next clk edge. SKID=0 build repeats the first and second scenarios: in_ready follows !out_valid|out_ready and occupancy never exceeds 1.

Source files
------------

// File: rtl/pipe_ctrl_stage.sv
// Pipeline-stage register for control bundles: valid/ready handshake, optional
// skid entry, and selective flush that keeps entries tagged noflush.
module pipe_ctrl_stage #(
  parameter int               WIDTH     = 16,
  parameter int               SKID      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_noflush,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_noflush,
  output logic [1:0]       occupancy
);

  logic             main_valid, skid_valid;
  logic [WIDTH-1:0] main_data, skid_data;
  logic             main_nf, skid_nf;

  logic             accept, pop;
  logic [2:0]       c_v, c_nf;
  logic [2:0][WIDTH-1:0] c_d;
  logic             nm_v, ns_v, nm_nf, ns_nf;
  logic [WIDTH-1:0] nm_d, ns_d;

  // SKID=1: in_ready is just the inverted skid flag, which is itself a register.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = ~skid_valid;
    end else begin : g_noskid
      assign in_ready = ~main_valid | out_ready;
    end
  endgenerate

  assign accept      = in_valid & in_ready;
  assign pop         = main_valid & out_ready;
  assign out_valid   = main_valid;
  assign out_data    = main_data;
  assign out_noflush = main_nf;

  // Oldest-first candidate list, filtered by flush, compacted into main then skid.
  always_comb begin
    c_v  = {accept, skid_valid, main_valid & ~pop};
    c_d  = {in_data, skid_data, main_data};
    c_nf = {in_noflush, skid_nf, main_nf};
    if (flush) c_v = c_v & c_nf;

    nm_v = 1'b0; nm_d = FLUSH_VAL; nm_nf = 1'b0;
    ns_v = 1'b0; ns_d = FLUSH_VAL; ns_nf = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (c_v[i]) begin
        if (!nm_v) begin
          nm_v = 1'b1; nm_d = c_d[i]; nm_nf = c_nf[i];
        end else if (!ns_v) begin
          ns_v = 1'b1; ns_d = c_d[i]; ns_nf = c_nf[i];
        end
      end
    end
    if (SKID == 0) begin
      ns_v = 1'b0; ns_d = FLUSH_VAL; ns_nf = 1'b0;
    end

    // An entry that was already empty keeps its payload unless flushed, so
    // the post-reset bubble still shows RESET_VAL.
    if (!nm_v && !main_valid && !flush) begin
      nm_d = main_data; nm_nf = main_nf;
    end
    if (!ns_v && !skid_valid && !flush) begin
      ns_d = skid_data; ns_nf = skid_nf;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= RESET_VAL;
      skid_data  <= RESET_VAL;
      main_nf    <= 1'b0;
      skid_nf    <= 1'b0;
      occupancy  <= 2'd0;
    end else begin
      main_valid <= nm_v;
      skid_valid <= ns_v;
      main_data  <= nm_d;
      skid_data  <= ns_d;
      main_nf    <= nm_nf;
      skid_nf    <= ns_nf;
      occupancy  <= {1'b0, nm_v} + {1'b0, ns_v};
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Directed table-driven bench for pipe_ctrl_stage, SKID=1 and SKID=0 builds.
module tb_pipe_ctrl_stage;

  localparam logic [15:0] RV = 16'hDEAD;
  localparam logic [15:0] FV = 16'hF00F;

  logic clk, reset;

  logic iv1, ir1, inf1, fl1, ov1, ordy1, onf1;
  logic [15:0] id1, od1;
  logic [1:0]  occ1;
  logic iv0, ir0, inf0, fl0, ov0, ordy0, onf0;
  logic [15:0] id0, od0;
  logic [1:0]  occ0;

  pipe_ctrl_stage #(.WIDTH(16), .SKID(1), .RESET_VAL(RV), .FLUSH_VAL(FV)) dut1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .in_noflush(inf1), .flush(fl1), .out_valid(ov1), .out_ready(ordy1),
    .out_data(od1), .out_noflush(onf1), .occupancy(occ1));

  pipe_ctrl_stage #(.WIDTH(16), .SKID(0), .RESET_VAL(RV), .FLUSH_VAL(FV)) dut0 (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .in_noflush(inf0), .flush(fl0), .out_valid(ov0), .out_ready(ordy0),
    .out_data(od0), .out_noflush(onf0), .occupancy(occ0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic iv; logic [15:0] id; logic inf; logic fl; logic ordy;
    logic e_ir; logic e_ov; logic [15:0] e_od; logic e_onf; logic [1:0] e_occ;
  } vec_t;

  int n_cmp = 0, n_fail = 0, pops1 = 0;
  vec_t tbl1[$], tbl0[$];

  // Delivered beats on the SKID=1 instance, sampled mid-cycle.
  always @(negedge clk) if (ov1 && ordy1) pops1++;

  function automatic vec_t mk(logic iv, logic [15:0] id, logic inf, logic fl, logic ordy,
                              logic e_ir, logic e_ov, logic [15:0] e_od, logic e_onf,
                              logic [1:0] e_occ);
    vec_t v;
    v.iv = iv; v.id = id; v.inf = inf; v.fl = fl; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_onf = e_onf; v.e_occ = e_occ;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // in_ready checked before the edge (the handshake value), outputs after it.
  task automatic run_vec(input vec_t v, input int sel, input string tag);
    if (sel == 1) begin
      iv1 = v.iv; id1 = v.id; inf1 = v.inf; fl1 = v.fl; ordy1 = v.ordy;
    end else begin
      iv0 = v.iv; id0 = v.id; inf0 = v.inf; fl0 = v.fl; ordy0 = v.ordy;
    end
    #1;
    chk({tag, ".in_ready"}, 32'(sel == 1 ? ir1 : ir0), 32'(v.e_ir));
    @(posedge clk); #1;
    chk({tag, ".out_valid"},   32'(sel == 1 ? ov1 : ov0),   32'(v.e_ov));
    chk({tag, ".out_data"},    32'(sel == 1 ? od1 : od0),   32'(v.e_od));
    chk({tag, ".out_noflush"}, 32'(sel == 1 ? onf1 : onf0), 32'(v.e_onf));
    chk({tag, ".occupancy"},   32'(sel == 1 ? occ1 : occ0), 32'(v.e_occ));
  endtask

  initial begin
    reset = 1'b1;
    iv1 = 0; id1 = '0; inf1 = 0; fl1 = 0; ordy1 = 0;
    iv0 = 0; id0 = '0; inf0 = 0; fl0 = 0; ordy0 = 0;

    //              iv id       nf fl rdy | ir ov data     nf occ
    // streaming at full rate
    tbl1.push_back(mk(1, 16'h0001, 0, 0, 1, 1, 1, 16'h0001, 0, 1));
    tbl1.push_back(mk(1, 16'h0002, 0, 0, 1, 1, 1, 16'h0002, 0, 1));
    tbl1.push_back(mk(1, 16'h0003, 0, 0, 1, 1, 1, 16'h0003, 0, 1));
    tbl1.push_back(mk(1, 16'h0004, 0, 0, 1, 1, 1, 16'h0004, 0, 1));
    tbl1.push_back(mk(0, 16'h0000, 0, 0, 1, 1, 0, FV,       0, 0));
    // back-pressure into the skid, then drain in order
    tbl1.push_back(mk(1, 16'h00A1, 0, 0, 0, 1, 1, 16'h00A1, 0, 1));
    tbl1.push_back(mk(1, 16'h00A2, 0, 0, 0, 1, 1, 16'h00A1, 0, 2));
    tbl1.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 1, 16'h00A1, 0, 2));
    tbl1.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 1, 16'h00A2, 0, 1));
    tbl1.push_back(mk(0, 16'h0000, 0, 0, 1, 1, 0, FV,       0, 0));
    // flush drops main, noflush skid compacts into main
    tbl1.push_back(mk(1, 16'h0011, 0, 0, 0, 1, 1, 16'h0011, 0, 1));
    tbl1.push_back(mk(1, 16'h0022, 1, 0, 0, 1, 1, 16'h0011, 0, 2));
    tbl1.push_back(mk(0, 16'h0000, 0, 1, 0, 0, 1, 16'h0022, 1, 1));
    tbl1.push_back(mk(0, 16'h0000, 0, 0, 1, 1, 0, FV,       0, 0));
    // flush kills a beat accepted the same cycle
    tbl1.push_back(mk(1, 16'h0033, 0, 1, 1, 1, 0, FV,       0, 0));
    // accept + pop with main full, skid empty
    tbl1.push_back(mk(1, 16'h0055, 0, 0, 1, 1, 1, 16'h0055, 0, 1));
    tbl1.push_back(mk(1, 16'h0066, 0, 0, 1, 1, 1, 16'h0066, 0, 1));
    tbl1.push_back(mk(0, 16'h0000, 0, 0, 1, 1, 0, FV,       0, 0));
    // flush keeps noflush main and a noflush incoming beat
    tbl1.push_back(mk(1, 16'h0077, 1, 0, 0, 1, 1, 16'h0077, 1, 1));
    tbl1.push_back(mk(1, 16'h0088, 1, 1, 0, 1, 1, 16'h0077, 1, 2));
    tbl1.push_back(mk(0, 16'h0000, 0, 0, 1, 0, 1, 16'h0088, 1, 1));
    tbl1.push_back(mk(0, 16'h0000, 0, 0, 1, 1, 0, FV,       0, 0));

    // SKID=0: combinational in_ready, never more than one entry
    tbl0.push_back(mk(1, 16'h0001, 0, 0, 1, 1, 1, 16'h0001, 0, 1));
    tbl0.push_back(mk(1, 16'h0002, 0, 0, 1, 1, 1, 16'h0002, 0, 1));
    tbl0.push_back(mk(1, 16'h0003, 0, 0, 1, 1, 1, 16'h0003, 0, 1));
    tbl0.push_back(mk(1, 16'h0004, 0, 0, 1, 1, 1, 16'h0004, 0, 1));
    tbl0.push_back(mk(0, 16'h0000, 0, 0, 1, 1, 0, FV,       0, 0));
    tbl0.push_back(mk(1, 16'h00A1, 0, 0, 0, 1, 1, 16'h00A1, 0, 1));
    tbl0.push_back(mk(1, 16'h00A2, 0, 0, 0, 0, 1, 16'h00A1, 0, 1));
    tbl0.push_back(mk(1, 16'h00A2, 0, 0, 1, 1, 1, 16'h00A2, 0, 1));
    tbl0.push_back(mk(0, 16'h0000, 0, 0, 1, 1, 0, FV,       0, 0));

    // reset state
    @(posedge clk); #1;
    chk("rst.out_valid",   32'(ov1),  32'd0);
    chk("rst.occupancy",   32'(occ1), 32'd0);
    chk("rst.out_data",    32'(od1),  32'(RV));
    chk("rst.out_noflush", 32'(onf1), 32'd0);
    chk("rst0.out_data",   32'(od0),  32'(RV));
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst.in_ready",  32'(ir1), 32'd1);
    chk("rst0.in_ready", 32'(ir0), 32'd1);
    chk("rst.bubble_data", 32'(od1), 32'(RV));

    for (int i = 0; i < tbl1.size(); i++) run_vec(tbl1[i], 1, $sformatf("s1v%0d", i));

    // flush in the same cycle as a pop: delivered exactly once
    begin
      int base;
      base = pops1;
      run_vec(mk(1, 16'h0044, 0, 0, 0, 1, 1, 16'h0044, 0, 1), 1, "fpop0");
      run_vec(mk(0, 16'h0000, 0, 1, 1, 1, 0, FV,       0, 0), 1, "fpop1");
      run_vec(mk(0, 16'h0000, 0, 0, 1, 1, 0, FV,       0, 0), 1, "fpop2");
      chk("fpop.delivered", 32'(pops1 - base), 32'd1);
    end

    // async reset mid-cycle with both entries full
    run_vec(mk(1, 16'h0101, 0, 0, 0, 1, 1, 16'h0101, 0, 1), 1, "arst0");
    run_vec(mk(1, 16'h0202, 1, 0, 0, 1, 1, 16'h0101, 0, 2), 1, "arst1");
    iv1 = 0;
    #2 reset = 1'b1;
    #1;
    chk("arst.out_valid", 32'(ov1),  32'd0);
    chk("arst.occupancy", 32'(occ1), 32'd0);
    chk("arst.out_data",  32'(od1),  32'(RV));
    chk("arst.in_ready",  32'(ir1),  32'd1);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    chk("arst.post_valid", 32'(ov1),  32'd0);
    chk("arst.post_occ",   32'(occ1), 32'd0);

    for (int i = 0; i < tbl0.size(); i++) run_vec(tbl0[i], 0, $sformatf("s0v%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete, expected finish before 20000");
    $fatal(1);
  end

endmodule
